// File: rtl/rom_arbiter_pkg.sv
// Shared types and defaults for the block-ROM arbiter.
// Tag struct rides the read-latency pipeline.
package rom_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 18;
  localparam int DEF_ROM_LAT = 2;
  localparam int PORT_W = 2;

  typedef struct packed {
    logic              vld;
    logic [PORT_W-1:0] port;
  } tag_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter.
// master = requesters, slave = arbiter.
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rom_arbiter_rr_arbiter.sv
// Round-robin pointer and one-hot grant.
// Search starts at ptr and wraps upward.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PORT_W-1:0]  gidx
);

  logic [PORT_W-1:0]  ptr;
  logic [NUM_REQ-1:0] rot;
  logic               found;
  int                 pos;

  // rotate requests so ptr sits at bit 0, pick the lowest set bit
  always_comb begin
    rot   = NUM_REQ'({valid, valid} >> ptr);
    found = 1'b0;
    pos   = 0;
    grant = '0;
    gidx  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        pos   = int'(ptr) + j;
      end
    end
    if (pos >= NUM_REQ) pos = pos - NUM_REQ;
    if (found && !rst) begin
      gidx  = PORT_W'(pos);
      grant = NUM_REQ'(1) << gidx;
    end
  end

  // advance past the winner on every accept
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (gidx == PORT_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one pipelined block ROM among NUM_REQ requesters.
// Optional ROM_ARB_STATS_EN adds grant/stall counters.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_REQ = 2,
  parameter int ROM_LAT = DEF_ROM_LAT,
  parameter int STATS_W = 16
) (
  input  logic              clka,
  input  logic              rst,
  rom_arbiter_if.slave      bus,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addra,
  output logic              rom_ena,
  output logic              rom_oe,
  input  logic [DATA_W-1:0] rom_douta
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] grant_cnt,
  output logic [NUM_REQ*STATS_W-1:0] stall_cnt
`endif
);

  logic [NUM_REQ-1:0] grant;
  logic [PORT_W-1:0]  gidx;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  logic [ADDR_W-1:0]  last_addr;
  logic [DATA_W-1:0]  rdata;
  logic [NUM_REQ-1:0] rsp;
  tag_t               pipe [ROM_LAT+1];

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk  (clka),
    .rst  (rst),
    .valid(bus.req_valid),
    .grant(grant),
    .gidx (gidx)
  );

  assign accept        = |grant;
  assign sel_addr      = bus.req_addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign bus.req_ready = grant;
  assign rom_ena       = accept;
  assign rom_addra     = accept ? sel_addr : last_addr;
  assign rom_oe        = pipe[ROM_LAT-1].vld & ~rst;
  assign bus.rsp_data  = rdata;
  assign bus.rsp_valid = rsp;

  // keep the ROM address parked while idle
  always_ff @(posedge clka) begin
    if (rst) begin
      last_addr <= '0;
    end else if (accept) begin
      last_addr <= sel_addr;
    end
  end

  // tag pipeline follows each read through the ROM latency
  always_ff @(posedge clka) begin
    if (rst) begin
      for (int k = 0; k <= ROM_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= {accept, gidx};
      for (int k = 1; k <= ROM_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // capture the ROM word while its owner sits at the output stage
  always_ff @(posedge clka) begin
    if (rst) begin
      rdata <= '0;
    end else if (pipe[ROM_LAT-1].vld) begin
      rdata <= rom_douta;
    end
  end

  // steer the response pulse and summarize in-flight reads
  always_comb begin
    rsp  = '0;
    busy = 1'b0;
    if (pipe[ROM_LAT].vld && !rst) begin
      rsp = NUM_REQ'(1) << pipe[ROM_LAT].port;
    end
    for (int k = 0; k <= ROM_LAT; k++) busy = busy | pipe[k].vld;
  end

`ifdef ROM_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [STATS_W-1:0] gc;
    logic [STATS_W-1:0] sc;

    // saturating per-port accept and stall counters
    always_ff @(posedge clka) begin
      if (rst) begin
        gc <= '0;
        sc <= '0;
      end else begin
        if (bus.req_valid[i] && grant[i] && !(&gc)) gc <= gc + 1'b1;
        if (bus.req_valid[i] && !grant[i] && !(&sc)) sc <= sc + 1'b1;
      end
    end

    assign grant_cnt[i*STATS_W +: STATS_W] = gc;
    assign stall_cnt[i*STATS_W +: STATS_W] = sc;
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter against a history-based model.
// Build with ROM_ARB_STATS_EN to also cover the counters.
module tb_rom_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int SW = 16;
  localparam int VW = N + 1 + AW + 1 + N + DW + 1;
  localparam int HN = 4096;

  logic clka = 1'b0;
  logic rst  = 1'b1;
  always #5 clka = ~clka;

  rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          busy;
  logic [AW-1:0] rom_addra;
  logic          rom_ena;
  logic          rom_oe;
  logic [DW-1:0] rom_douta;
  logic [DW-1:0] m1;
  logic [DW-1:0] dreg;
`ifdef ROM_ARB_STATS_EN
  logic [N*SW-1:0] grant_cnt;
  logic [N*SW-1:0] stall_cnt;
`endif

  rom_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REQ(N), .ROM_LAT(2), .STATS_W(SW)
  ) dut (
    .clka     (clka),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .rom_addra(rom_addra),
    .rom_ena  (rom_ena),
    .rom_oe   (rom_oe),
    .rom_douta(rom_douta)
`ifdef ROM_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] memv(input logic [AW-1:0] a);
    return DW'(a) ^ 18'h2AAAA;
  endfunction

  // two-stage ROM: internal register then douta_reg
  always @(posedge clka) begin
    if (rom_ena) m1 <= memv(rom_addra);
    dreg <= m1;
  end
  assign rom_douta = rom_oe ? dreg : '0;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int ptr_m = 0;
  bit hv [HN];
  int hp [HN];
  logic [AW-1:0] ha [HN];
  logic [AW-1:0] last_m = '0;
  logic [DW-1:0] data_m = '0;
  int gc_m [N];
  int sc_m [N];
  logic [VW-1:0] e_vec;

  function automatic bit hvat(input int k);
    return (k >= 0) ? hv[k % HN] : 1'b0;
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.req_ready, rom_ena, rom_addra, rom_oe,
            bus.rsp_valid, bus.rsp_data, busy};
  endfunction

  function automatic void calc_exp();
    int g;
    logic [N-1:0] rdy, rv;
    logic [AW-1:0] ad;
    g   = rst ? -1 : pick(bus.req_valid);
    rdy = (g >= 0) ? N'(1) << g : '0;
    ad  = (g >= 0) ? bus.req_addr[g*AW +: AW] : last_m;
    rv  = '0;
    if (!rst && hvat(cyc - 3)) rv = N'(1) << hp[(cyc - 3) % HN];
    e_vec = {rdy, g >= 0, ad, !rst && hvat(cyc - 2), rv, data_m,
             hvat(cyc - 1) | hvat(cyc - 2) | hvat(cyc - 3)};
  endfunction

  // model: record accepts per cycle, react to reset at the edge
  always @(posedge clka) begin
    int g;
    g = rst ? -1 : pick(bus.req_valid);
    if (rst) begin
      for (int k = 0; k < HN; k++) hv[k] = 1'b0;
      ptr_m  = 0;
      last_m = '0;
      data_m = '0;
      for (int p = 0; p < N; p++) begin
        gc_m[p] = 0;
        sc_m[p] = 0;
      end
    end else begin
      if (hvat(cyc - 2)) data_m = memv(ha[(cyc - 2) % HN]);
      hv[cyc % HN] = (g >= 0);
      for (int p = 0; p < N; p++) begin
        if (bus.req_valid[p] && g == p && gc_m[p] < (1 << SW) - 1)
          gc_m[p]++;
        if (bus.req_valid[p] && g != p && sc_m[p] < (1 << SW) - 1)
          sc_m[p]++;
      end
      if (g >= 0) begin
        hp[cyc % HN] = g;
        ha[cyc % HN] = bus.req_addr[g*AW +: AW];
        last_m = bus.req_addr[g*AW +: AW];
        ptr_m  = (g + 1) % N;
      end
    end
    cyc++;
  end

  task automatic drive(input logic r, input logic [N-1:0] v,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(posedge clka);
    #1;
    rst = r;
    bus.req_valid = v;
    bus.req_addr = {a1, a0};
    @(negedge clka);
    calc_exp();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 10'h155, 10'h2AA);
      nchk++;
      if (obs_vec() !== e_vec || obs_vec() !== '0) begin
        nerr++;
        $display("FAIL reset c%0d got=%h exp=%h", i, obs_vec(), e_vec);
      end
    end
  endtask

  task automatic test_single_read();
    logic [DW-1:0] want;
    want = 18'h2AAAF;
    drive(1'b0, 2'b01, 10'h005, 10'h000);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drive(1'b0, 2'b00, 10'h000, 10'h000);
      nchk++;
      if (obs_vec() !== e_vec) begin
        nerr++;
        $display("FAIL single t+%0d got=%h exp=%h", i, obs_vec(), e_vec);
      end
      if (i == 3) begin
        nchk++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== want) begin
          nerr++;
          $display("FAIL single_rsp got=%b/%h exp=01/%h",
                   bus.rsp_valid, bus.rsp_data, want);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] wg;
    drive(1'b1, 2'b00, 10'h000, 10'h000);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'b11, 10'h010, 10'h3FF);
      wg = (i % 2 == 0) ? 2'b01 : 2'b10;
      nchk++;
      if (obs_vec() !== e_vec || bus.req_ready !== wg) begin
        nerr++;
        $display("FAIL contend c%0d got=%h exp=%h", i, obs_vec(), e_vec);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b00, 10'h000, 10'h000);
      nchk++;
      if (obs_vec() !== e_vec) begin
        nerr++;
        $display("FAIL contend_drain c%0d got=%h exp=%h",
                 i, obs_vec(), e_vec);
      end
    end
`ifdef ROM_ARB_STATS_EN
    for (int p = 0; p < N; p++) begin
      nchk++;
      if (grant_cnt[p*SW +: SW] !== SW'(gc_m[p]) || gc_m[p] != 3 ||
          stall_cnt[p*SW +: SW] !== SW'(sc_m[p]) || sc_m[p] != 3) begin
        nerr++;
        $display("FAIL stats p%0d got=%0d/%0d exp=3/3", p,
                 grant_cnt[p*SW +: SW], stall_cnt[p*SW +: SW]);
      end
    end
`endif
  endtask

  task automatic test_stream();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) drive(1'b0, 2'b10, 10'h000, AW'(i));
      else drive(1'b0, 2'b00, 10'h000, 10'h000);
      if (bus.rsp_valid == 2'b10) pulses++;
      nchk++;
      if (obs_vec() !== e_vec) begin
        nerr++;
        $display("FAIL stream c%0d got=%h exp=%h", i, obs_vec(), e_vec);
      end
    end
    nchk++;
    if (pulses != 8) begin
      nerr++;
      $display("FAIL stream_pulses got=%0d exp=8", pulses);
    end
  endtask

  task automatic test_idle();
    logic [AW-1:0] held;
    held = rom_addra;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'b00, AW'($urandom), AW'($urandom));
      nchk++;
      if (obs_vec() !== e_vec || rom_addra !== held ||
          rom_ena !== 1'b0 || rom_oe !== 1'b0) begin
        nerr++;
        $display("FAIL idle c%0d got=%h exp=%h", i, obs_vec(), e_vec);
      end
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b0, 2'b01, 10'h123, 10'h000);
    drive(1'b0, 2'b10, 10'h000, 10'h000);
    drive(1'b1, 2'b00, 10'h000, 10'h000);
    nchk++;
    if (obs_vec() !== e_vec || rom_oe !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_cyc got=%h exp=%h", obs_vec(), e_vec);
    end
    drive(1'b0, 2'b10, 10'h000, 10'h3FF);
    nchk++;
    if (obs_vec() !== e_vec || bus.req_ready !== 2'b10 ||
        busy !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_after got=%h exp=%h", obs_vec(), e_vec);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b00, 10'h000, 10'h000);
      nchk++;
      if (obs_vec() !== e_vec) begin
        nerr++;
        $display("FAIL midrst_drain c%0d got=%h exp=%h",
                 i, obs_vec(), e_vec);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a [N];
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < N; p++) begin
        case ($urandom_range(0, 3))
          0: a[p] = '0;
          1: a[p] = '1;
          default: a[p] = AW'($urandom);
        endcase
      end
      drive($urandom_range(0, 49) == 0, N'($urandom), a[0], a[1]);
      nchk++;
      if (obs_vec() !== e_vec) begin
        nerr++;
        $display("FAIL random c%0d got=%h exp=%h", i, obs_vec(), e_vec);
      end
    end
  endtask

`ifdef ROM_ARB_STATS_EN
  task automatic test_saturate();
    drive(1'b1, 2'b00, 10'h000, 10'h000);
    for (int i = 0; i < (1 << SW) + 5; i++)
      drive(1'b0, 2'b01, 10'h001, 10'h000);
    drive(1'b0, 2'b00, 10'h000, 10'h000);
    nchk++;
    if (grant_cnt[SW-1:0] !== 16'hFFFF ||
        grant_cnt[SW-1:0] !== SW'(gc_m[0])) begin
      nerr++;
      $display("FAIL saturate got=%h exp=ffff", grant_cnt[SW-1:0]);
    end
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_stream();
    test_idle();
    test_reset_midflight();
    test_random();
`ifdef ROM_ARB_STATS_EN
    test_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
